mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port of the multi-cycle core between the

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/LS requesters, the shared memory port and the arbiter.
// The arbiter takes the slave view; the requester/memory environment takes the master view.
interface mem_port_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;

  logic        ls_req_valid;
  logic        ls_req_ready;
  logic [31:0] ls_addr;
  logic        ls_we;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_be;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  logic        timeout_err;

  modport slave (
    input  if_req_valid, if_addr,
    input  ls_req_valid, ls_addr, ls_we, ls_wdata, ls_be,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_be,
    output timeout_err
  );

  modport master (
    output if_req_valid, if_addr,
    output ls_req_valid, ls_addr, ls_we, ls_wdata, ls_be,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_be,
    input  timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction in flight, with a watchdog.
// Accept cycle N, mem request N+1, earliest response N+2; requesters see ready=0 until back in IDLE.
module mem_port_arbiter #(
  parameter bit          LS_PRIORITY = 1'b1,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  localparam int unsigned     WD_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned     WD_LIM_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [WD_W-1:0] WD_LIM   = WD_LIM_I[WD_W-1:0];
  localparam bit              WD_ON    = (TIMEOUT != 0);

  state_t          state_q, state_d;
  logic            owner_ls_q, rr_last_ls_q;
  logic [WD_W-1:0] wd_q;
  logic            timeout_err_q;
  logic            mem_req_valid_q, mem_we_q;
  logic [31:0]     mem_addr_q, mem_wdata_q;
  logic [3:0]      mem_be_q;

  logic            grant_ls, accept, wd_fire, rsp_fire, req_abort, rsp_abort;
  logic [31:0]     rsp_data;

  // wd_fire marks the last cycle a transaction may spend in REQ+RESP.
  always_comb begin
    if (bus.if_req_valid && bus.ls_req_valid)
      grant_ls = LS_PRIORITY ? 1'b1 : ~rr_last_ls_q;
    else
      grant_ls = bus.ls_req_valid;
    accept    = (state_q == IDLE) && (bus.if_req_valid || bus.ls_req_valid);
    wd_fire   = WD_ON && (wd_q >= WD_LIM);
    req_abort = (state_q == REQ) && wd_fire && !bus.mem_req_ready;
    rsp_fire  = (state_q == RESP) && (bus.mem_rsp_valid || wd_fire);
    rsp_abort = (state_q == RESP) && wd_fire && !bus.mem_rsp_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (bus.mem_req_ready) state_d = RESP;
               else if (wd_fire)      state_d = IDLE;
      RESP:    if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.if_req_ready = 1'b0;
    bus.ls_req_ready = 1'b0;
    bus.if_rsp_valid = 1'b0;
    bus.ls_rsp_valid = 1'b0;
    bus.if_rsp_data  = '0;
    bus.ls_rsp_data  = '0;
    rsp_data         = '0;
    if (state_q == IDLE) begin
      bus.ls_req_ready = grant_ls;
      bus.if_req_ready = bus.if_req_valid & ~grant_ls;
    end
    // A watchdog abort still completes the owner's handshake, with zero data.
    if (rsp_fire) begin
      rsp_data         = (bus.mem_rsp_valid && !mem_we_q) ? bus.mem_rsp_data : '0;
      bus.ls_rsp_valid = owner_ls_q;
      bus.if_rsp_valid = ~owner_ls_q;
      bus.ls_rsp_data  = owner_ls_q ? rsp_data : '0;
      bus.if_rsp_data  = owner_ls_q ? '0 : rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_ls_q      <= 1'b0;
      rr_last_ls_q    <= 1'b0;
      wd_q            <= '0;
      timeout_err_q   <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_be_q        <= '0;
    end else begin
      if (accept) begin
        owner_ls_q      <= grant_ls;
        rr_last_ls_q    <= grant_ls;
        mem_req_valid_q <= 1'b1;
        mem_addr_q      <= grant_ls ? bus.ls_addr : bus.if_addr;
        mem_we_q        <= grant_ls & bus.ls_we;
        mem_wdata_q     <= grant_ls ? bus.ls_wdata : '0;
        mem_be_q        <= grant_ls ? bus.ls_be : 4'hF;
        wd_q            <= '0;
      end
      if ((state_q == REQ) && (bus.mem_req_ready || wd_fire))
        mem_req_valid_q <= 1'b0;
      if (((state_q == REQ) || (state_q == RESP)) && (wd_q != WD_LIM))
        wd_q <= wd_q + WD_W'(1);
      if (req_abort || rsp_abort)
        timeout_err_q <= 1'b1;
    end
  end

  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_be        = mem_be_q;
  assign bus.timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized transactions on two arbiter instances (LS-priority and round-robin),
// each transaction's grant, memory fields, response and watchdog outcome predicted from the rules.
module tb_mem_port_arbiter;
  localparam int TO    = 8;
  localparam int NEVER = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if pif ();
  mem_port_arbiter_if rif ();

  mem_port_arbiter #(.LS_PRIORITY(1'b1), .TIMEOUT(TO)) u_pri (.clk(clk), .rst_n(rst_n), .bus(pif.slave));
  mem_port_arbiter #(.LS_PRIORITY(1'b0), .TIMEOUT(TO)) u_rr  (.clk(clk), .rst_n(rst_n), .bus(rif.slave));

  int   n_cmp    = 0;
  int   n_bad    = 0;
  logic exp_terr = 1'b0;
  bit   last_ls  = 1'b0;
  bit   rr_win;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    pif.if_req_valid = 0; pif.if_addr = 0; pif.ls_req_valid = 0; pif.ls_addr = 0;
    pif.ls_we = 0; pif.ls_wdata = 0; pif.ls_be = 0;
    pif.mem_req_ready = 0; pif.mem_rsp_valid = 0; pif.mem_rsp_data = 0;
    rif.if_req_valid = 0; rif.if_addr = 0; rif.ls_req_valid = 0; rif.ls_addr = 0;
    rif.ls_we = 0; rif.ls_wdata = 0; rif.ls_be = 0;
    rif.mem_req_ready = 0; rif.mem_rsp_valid = 0; rif.mem_rsp_data = 0;
  endtask

  task automatic chk_pri_zero(input string p);
    chk({p, ".if_req_ready"},  pif.if_req_ready,  0);
    chk({p, ".ls_req_ready"},  pif.ls_req_ready,  0);
    chk({p, ".if_rsp_valid"},  pif.if_rsp_valid,  0);
    chk({p, ".ls_rsp_valid"},  pif.ls_rsp_valid,  0);
    chk({p, ".if_rsp_data"},   pif.if_rsp_data,   0);
    chk({p, ".ls_rsp_data"},   pif.ls_rsp_data,   0);
    chk({p, ".mem_req_valid"}, pif.mem_req_valid, 0);
    chk({p, ".mem_addr"},      pif.mem_addr,      0);
    chk({p, ".mem_we"},        pif.mem_we,        0);
    chk({p, ".mem_wdata"},     pif.mem_wdata,     0);
    chk({p, ".mem_be"},        pif.mem_be,        0);
    chk({p, ".timeout_err"},   pif.timeout_err,   0);
  endtask

  // One transaction on the LS-priority instance. d_rdy: cycles mem_req_ready stays low in REQ;
  // d_rsp: cycles of silence in RESP before the response (NEVER = memory is dead).
  task automatic run_txn(input bit if_v, input bit ls_v, input logic [31:0] ia, input logic [31:0] la,
                         input bit we, input logic [31:0] wd, input logic [3:0] be,
                         input int d_rdy, input int d_rsp, input logic [31:0] rdata);
    bit          win_ls, abort_req, abort_rsp, fire;
    logic [31:0] e_addr, e_wd, e_data;
    logic [3:0]  e_be;
    bit          e_we;
    win_ls    = ls_v;
    abort_req = (d_rdy >= TO);
    abort_rsp = !abort_req && (d_rdy + 2 + d_rsp > TO);
    e_addr    = win_ls ? la : ia;
    e_we      = win_ls ? we : 1'b0;
    e_wd      = win_ls ? wd : 32'h0;
    e_be      = win_ls ? be : 4'hF;
    e_data    = (abort_rsp || e_we) ? 32'h0 : rdata;

    @(negedge clk);
    pif.if_req_valid = if_v; pif.if_addr = ia;
    pif.ls_req_valid = ls_v; pif.ls_addr = la; pif.ls_we = we; pif.ls_wdata = wd; pif.ls_be = be;
    pif.mem_req_ready = 0;
    pif.mem_rsp_valid = 1'($urandom_range(0, 1));
    pif.mem_rsp_data  = $urandom;
    #1;
    chk("idle.if_req_ready", pif.if_req_ready, if_v && !win_ls);
    chk("idle.ls_req_ready", pif.ls_req_ready, win_ls);
    chk("idle.mem_req_valid", pif.mem_req_valid, 0);
    chk("idle.rsp_valids", {pif.if_rsp_valid, pif.ls_rsp_valid}, 0);
    chk("idle.timeout_err", pif.timeout_err, exp_terr);

    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      if (win_ls) pif.ls_req_valid = 0; else pif.if_req_valid = 0;
      pif.mem_req_ready = (i == d_rdy);
      pif.mem_rsp_valid = 1'($urandom_range(0, 1));
      #1;
      chk("req.mem_req_valid", pif.mem_req_valid, 1);
      chk("req.mem_addr", pif.mem_addr, e_addr);
      chk("req.mem_we", pif.mem_we, e_we);
      chk("req.mem_wdata", pif.mem_wdata, e_wd);
      chk("req.mem_be", pif.mem_be, e_be);
      chk("req.readies", {pif.if_req_ready, pif.ls_req_ready}, 0);
      chk("req.rsp_valids", {pif.if_rsp_valid, pif.ls_rsp_valid}, 0);
      if (i == d_rdy) break;
    end

    if (abort_req) exp_terr = 1'b1;
    else begin
      for (int j = 0; j < TO; j++) begin
        @(negedge clk);
        pif.mem_req_ready = 0;
        pif.mem_rsp_valid = (j == d_rsp);
        pif.mem_rsp_data  = rdata;
        #1;
        fire = (j == d_rsp) || (d_rdy + 2 + j == TO);
        chk("rsp.mem_req_valid", pif.mem_req_valid, 0);
        chk("rsp.readies", {pif.if_req_ready, pif.ls_req_ready}, 0);
        chk("rsp.if_rsp_valid", pif.if_rsp_valid, fire && !win_ls);
        chk("rsp.ls_rsp_valid", pif.ls_rsp_valid, fire && win_ls);
        chk("rsp.if_rsp_data", pif.if_rsp_data, (fire && !win_ls) ? e_data : 32'h0);
        chk("rsp.ls_rsp_data", pif.ls_rsp_data, (fire && win_ls) ? e_data : 32'h0);
        if (fire) break;
      end
      if (abort_rsp) exp_terr = 1'b1;
    end
  endtask

  task automatic park();
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    bit          rv_if, rv_ls, rv_we;
    clear_inputs();
    #12;
    chk_pri_zero("reset");
    chk("reset.rr_mem_req_valid", rif.mem_req_valid, 0);
    chk("reset.rr_readies", {rif.if_req_ready, rif.ls_req_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch only, response two cycles after the request is taken.
    run_txn(1, 0, 32'h0000_0010, 32'h0, 0, 32'h0, 4'h0, 0, 1, 32'h0013_0093);
    // Tie with LS priority: LS store first, then the held fetch.
    run_txn(1, 1, 32'h0000_0014, 32'h0000_0100, 1, 32'hDEAD_BEEF, 4'h3, 0, 0, 32'h1234_5678);
    run_txn(1, 0, 32'h0000_0014, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h0000_0513);
    // Memory stalls the request for 5 cycles.
    run_txn(0, 1, 32'h0, 32'h0000_0200, 0, 32'h0, 4'hF, 5, 0, 32'hCAFE_F00D);
    // Response lands in the last allowed cycle: response wins, no error.
    run_txn(1, 0, 32'h0000_0040, 32'h0, 0, 32'h0, 4'h0, 0, 6, 32'h0BAD_C0DE);
    run_txn(0, 1, 32'h0, 32'h0000_0300, 0, 32'h0, 4'hF, 6, 0, 32'h5555_AAAA);
    park();

    // Round-robin instance with both requesters held valid.
    @(negedge clk);
    rif.if_req_valid = 1; rif.if_addr = 32'h0000_0080;
    rif.ls_req_valid = 1; rif.ls_addr = 32'h0000_0400; rif.ls_be = 4'h5;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      rif.mem_req_ready = 0; rif.mem_rsp_valid = 0;
      rr_win  = !last_ls;
      last_ls = rr_win;
      #1;
      chk("rr.ls_req_ready", rif.ls_req_ready, rr_win);
      chk("rr.if_req_ready", rif.if_req_ready, !rr_win);
      @(negedge clk);
      rif.mem_req_ready = 1;
      #1;
      chk("rr.mem_be", rif.mem_be, rr_win ? 4'h5 : 4'hF);
      @(negedge clk);
      rif.mem_req_ready = 0; rif.mem_rsp_valid = 1; rif.mem_rsp_data = 32'h100 + k;
      #1;
      chk("rr.ls_rsp_valid", rif.ls_rsp_valid, rr_win);
      chk("rr.if_rsp_valid", rif.if_rsp_valid, !rr_win);
    end
    park();

    // Randomized traffic, delays chosen so the watchdog never trips.
    for (int k = 0; k < 40; k++) begin
      rv_if = 1'($urandom_range(0, 1));
      rv_ls = 1'($urandom_range(0, 1));
      if (!rv_if && !rv_ls) rv_if = 1;
      rv_we = 1'($urandom_range(0, 1));
      run_txn(rv_if, rv_ls, $urandom, $urandom, rv_we, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    // Dead memory in RESP, then a normal transaction with the error still flagged.
    run_txn(1, 0, 32'h0000_0500, 32'h0, 0, 32'h0, 4'h0, 0, NEVER, 32'hFFFF_FFFF);
    run_txn(0, 1, 32'h0, 32'h0000_0600, 0, 32'h0, 4'hF, 1, 1, 32'h7777_1111);
    // Memory never accepts the request.
    run_txn(0, 1, 32'h0, 32'h0000_0700, 1, 32'h1111_2222, 4'hC, NEVER, 0, 32'h0);
    run_txn(1, 0, 32'h0000_0704, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h9999_0000);

    // Reset while waiting in RESP, then a stray late response.
    @(negedge clk);
    pif.if_req_valid = 1; pif.if_addr = 32'h0000_0800; pif.mem_rsp_valid = 0;
    @(negedge clk);
    pif.if_req_valid = 0; pif.mem_req_ready = 1;
    @(negedge clk);
    pif.mem_req_ready = 0;
    rst_n = 1'b0;
    exp_terr = 1'b0;
    #1;
    chk_pri_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    pif.mem_rsp_valid = 1; pif.mem_rsp_data = 32'hABCD_0123;
    #1;
    chk("stray.rsp_valids", {pif.if_rsp_valid, pif.ls_rsp_valid}, 0);
    chk("stray.if_rsp_data", pif.if_rsp_data, 0);
    chk("stray.mem_req_valid", pif.mem_req_valid, 0);
    chk("stray.timeout_err", pif.timeout_err, 0);
    park();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
